run_detect_sched: RTL and testbench

Round-robin scheduler and context controller that time-shares one run-length detector (same-bit run of RUN_LEN or more) across N_CH serial bit channels. Each cycle it grants at most one requesting channel, runs that channel's bit through the shared detection step using the channel's stored context, and reports a registered result tagged with the channel number. It sits between the per-channel serial sources and downstream logic that previously needed one Mealy detector per channel.

---
 rtl/run_detect_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/run_detect_sched.sv | 108 ++++++++++
 tb/tb_run_detect_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/run_detect_pkg.sv
// Shared types and helpers for the time-shared run-length detector.
// Holds per-channel context layout and the saturating count step.
package run_detect_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int RUN_LEN_DEF = 4;
    localparam int CTX_CNT_W   = 8;

    typedef struct packed {
        logic                 has_hist;
        logic                 last_bit;
        logic [CTX_CNT_W-1:0] cnt;
    } ctx_t;

    localparam ctx_t CTX_IDLE = '0;

    function automatic logic [CTX_CNT_W-1:0] sat_inc(
        input logic [CTX_CNT_W-1:0] cnt,
        input logic [CTX_CNT_W-1:0] lim
    );
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

    function automatic logic [CTX_CNT_W-1:0] next_cnt(
        input ctx_t                 ctx,
        input logic                 b,
        input logic [CTX_CNT_W-1:0] lim
    );
        if (ctx.has_hist && (b == ctx.last_bit)) begin
            return sat_inc(ctx.cnt, lim);
        end
        return CTX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    // search ptr, ptr+1, ... modulo N_CH and keep the first hit
    always_comb begin
        logic [CH_W:0]   s;
        logic [CH_W-1:0] j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = '0;
        j   = '0;
        for (int k = 0; k < N_CH; k++) begin
            s = {1'b0, ptr} + (CH_W+1)'(k);
            if (s >= (CH_W+1)'(N_CH)) begin
                s = s - (CH_W+1)'(N_CH);
            end
            j = s[CH_W-1:0];
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/run_detect_sched.sv
// Scheduler sharing one run-length detection step over N_CH channels.
// Context bank, grant pointer and registered result live here.
module run_detect_sched
    import run_detect_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] bit_in,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] ack,
    output logic            det_valid,
    output logic [CH_W-1:0] det_ch,
    output logic            det_out
);

    ctx_t            ctx_q [N_CH];
    ctx_t            ctx_d [N_CH];
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            det_valid_q, det_valid_d;
    logic [CH_W-1:0] det_ch_q, det_ch_d;
    logic            det_out_q, det_out_d;

    logic [N_CH-1:0] gnt;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_any;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // grant is suppressed while reset is held
    always_comb begin
        ack = RESET ? '0 : gnt;
    end

    // clears land first, then the granted bit runs the detection step
    always_comb begin
        ctx_t           cur;
        logic [CNT_W-1:0] new_cnt;
        logic           hit;
        ctx_d       = ctx_q;
        cur         = CTX_IDLE;
        new_cnt     = '0;
        hit         = 1'b0;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        det_out_d   = det_out_q;
        for (int i = 0; i < N_CH; i++) begin
            if (clr[i]) begin
                ctx_d[i] = CTX_IDLE;
            end
        end
        if (gnt_any) begin
            cur     = ctx_d[gnt_idx];
            new_cnt = CNT_W'(next_cnt(cur, bit_in[gnt_idx],
                                      CTX_CNT_W'(RUN_LEN)));
            hit     = (new_cnt == CNT_W'(RUN_LEN));
            ctx_d[gnt_idx] = '{has_hist: 1'b1,
                               last_bit: bit_in[gnt_idx],
                               cnt:      CTX_CNT_W'(new_cnt)};
            ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0
                                                  : gnt_idx + 1'b1;
            det_valid_d = 1'b1;
            det_ch_d    = gnt_idx;
            det_out_d   = hit;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RESET) begin
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_out_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ctx_q[i] <= CTX_IDLE;
            end
        end else begin
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_out_q   <= det_out_d;
            for (int i = 0; i < N_CH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign det_out   = det_out_q;

endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: reference model plus directed sequences.
// Model works on plain integer arrays per channel.
module tb_run_detect_sched;

    localparam int N  = 4;
    localparam int RL = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          RESET;
    logic [N-1:0]  req, bit_in, clr, ack;
    logic          det_valid, det_out;
    logic [CW-1:0] det_ch;

    int passes = 0;
    int checks = 0;
    bit check_en = 1'b0;

    int m_hist [N];
    int m_last [N];
    int m_cnt  [N];
    int m_ptr;
    int e_valid, e_ch, e_out;

    int dlog_ch  [$];
    int dlog_out [$];
    int alog     [$];

    run_detect_sched #(.N_CH(N), .RUN_LEN(RL)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .req       (req),
        .bit_in    (bit_in),
        .clr       (clr),
        .ack       (ack),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_out   (det_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hist[i] = 0; m_last[i] = 0; m_cnt[i] = 0;
        end
        m_ptr = 0; e_valid = 0; e_ch = 0; e_out = 0;
    endtask

    // compare against model each cycle, then advance the model
    always @(negedge clk) begin
        if (check_en) begin
            int g;
            int b;
            g = -1;
            if (!RESET) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && req[j]) g = j;
                end
            end
            chk("ack", int'(ack), (g < 0) ? 0 : (1 << g));
            chk("det_valid", int'(det_valid), e_valid);
            chk("det_ch", int'(det_ch), e_ch);
            chk("det_out", int'(det_out), e_out);
            if (det_valid) begin
                dlog_ch.push_back(int'(det_ch));
                dlog_out.push_back(int'(det_out));
            end
            if (ack != 0) alog.push_back(int'(ack));
            if (RESET) begin
                model_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (clr[i]) begin
                        m_hist[i] = 0; m_last[i] = 0; m_cnt[i] = 0;
                    end
                end
                if (g >= 0) begin
                    b = int'(bit_in[g]);
                    if (m_hist[g] == 1 && m_last[g] == b)
                        m_cnt[g] = (m_cnt[g] + 1 > RL) ? RL : m_cnt[g] + 1;
                    else
                        m_cnt[g] = 1;
                    m_hist[g] = 1;
                    m_last[g] = b;
                    m_ptr = (g + 1) % N;
                    e_valid = 1; e_ch = g;
                    e_out = (m_cnt[g] == RL) ? 1 : 0;
                end else begin
                    e_valid = 0;
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic rst);
        req = r; bit_in = b; clr = c; RESET = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        dlog_ch.delete(); dlog_out.delete(); alog.delete();
    endtask

    task automatic chk_outs(input string nm, input int ch,
                            input logic [15:0] exp, input int n);
        chk({nm, "_len"}, dlog_out.size(), n);
        for (int k = 0; k < n && k < dlog_out.size(); k++) begin
            chk({nm, "_out"}, dlog_out[k], int'(exp[k]));
            if (ch >= 0) chk({nm, "_ch"}, dlog_ch[k], ch);
        end
    endtask

    logic [7:0]  seq;
    logic [15:0] ex;
    logic [N-1:0] cur_b;

    initial begin
        model_reset();
        req = '0; bit_in = '0; clr = '0; RESET = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        drive('0, '0, '0, 1'b1);

        // channel 0: 1,1,1,1,1,0,0,1 (k-th bit is seq[k])
        clear_logs();
        seq = 8'b1001_1111;
        for (int k = 0; k < 8; k++) drive(4'b0001, {3'b0, seq[k]}, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        ex = 16'b0000_0000_0001_1000;
        chk_outs("ch0_seq", 0, ex, 8);

        // channel 1: 0,0,0,0,0,1,1,0
        clear_logs();
        seq = 8'b0110_0000;
        for (int k = 0; k < 8; k++) drive(4'b0010, {2'b0, seq[k], 1'b0}, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        chk_outs("ch1_seq", 1, ex, 8);

        // all four channels continuously
        drive('0, '0, '0, 1'b1);
        clear_logs();
        for (int k = 0; k < 16; k++) drive(4'b1111, 4'b1010, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        chk("rr_ack0", alog[0], 1);
        chk("rr_ack1", alog[1], 2);
        chk("rr_ack2", alog[2], 4);
        chk("rr_ack3", alog[3], 8);
        chk("rr_ack4", alog[4], 1);
        ex = 16'b1111_0000_0000_0000;
        chk_outs("rr4", -1, ex, 16);

        // wrap from ptr=3
        drive(4'b0100, '0, '0, 1'b0);
        clear_logs();
        drive(4'b1001, '0, '0, 1'b0);
        drive(4'b0001, '0, '0, 1'b0);
        drive(4'b0011, '0, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        chk("wrap_n", alog.size(), 3);
        chk("wrap_a0", alog[0], 8);
        chk("wrap_a1", alog[1], 1);
        chk("wrap_a2", alog[2], 2);

        // clear collides with grant on channel 2
        drive('0, '0, '0, 1'b1);
        clear_logs();
        for (int k = 0; k < 3; k++) drive(4'b0100, 4'b0100, '0, 1'b0);
        drive(4'b0100, 4'b0100, 4'b0100, 1'b0);
        for (int k = 0; k < 3; k++) drive(4'b0100, 4'b0100, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        ex = 16'b0000_0000_0100_0000;
        chk_outs("clr2", 2, ex, 7);

        // reset in the middle of a run on channel 0
        drive('0, '0, '0, 1'b1);
        clear_logs();
        for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0001, '0, 1'b0);
        drive(4'b0001, 4'b0001, '0, 1'b1);
        drive(4'b0011, 4'b0011, '0, 1'b0);
        for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0001, '0, 1'b0);
        drive('0, '0, '0, 1'b0);
        chk_outs("rst_mid", 0, ex, 7);
        chk("rst_ptr", alog[3], 1);

        // randomized traffic with run-friendly bits
        cur_b = '0;
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r, c;
            r = N'($urandom);
            c = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0) cur_b[i] = ~cur_b[i];
                if ($urandom_range(0, 29) == 0) c[i] = 1'b1;
            end
            drive(r, cur_b, c, ($urandom_range(0, 199) == 0));
        end
        drive('0, '0, '0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
